// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM state encoding and default widths.
package mem_port_arbiter_pkg;

    localparam int ARB_AW = 16;
    localparam int ARB_DW = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_D    = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational grant select: a requester whose ready is high is ineligible, and a tie goes to
// whichever side did not win the previous grant.
module arb_pick (
    input  logic if_req,
    input  logic if_ready,
    input  logic d_req,
    input  logic d_ready,
    input  logic last_d,
    output logic grant_if,
    output logic grant_d
);

    logic if_elig;
    logic d_elig;

    assign if_elig  = if_req & ~if_ready;
    assign d_elig   = d_req & ~d_ready;
    // Data wins ties unless it won last time, so fetch is never starved.
    assign grant_d  = d_elig & (~if_elig | ~last_d);
    assign grant_if = if_elig & ~grant_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port instruction/data memory between fetch and the mem stage, one
// req/ack transaction at a time, and produces the per-stage stall signals.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          busy
);

    arb_state_e state;
    arb_state_e state_next;
    logic       last_d;
    logic       grant_if;
    logic       grant_d;

    arb_pick u_pick (
        .if_req   (if_req),
        .if_ready (if_ready),
        .d_req    (d_req),
        .d_ready  (d_ready),
        .last_d   (last_d),
        .grant_if (grant_if),
        .grant_d  (grant_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: begin
                if (grant_d) begin
                    state_next = ARB_D;
                end else if (grant_if) begin
                    state_next = ARB_IF;
                end
            end
            ARB_IF, ARB_D: begin
                if (mem_ack) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Memory-side signals stay frozen while a transaction is in flight; ready pulses one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            last_d    <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        last_d    <= 1'b1;
                    end else if (grant_if) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                        last_d   <= 1'b0;
                    end
                end
                ARB_IF: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        if_ready <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
                ARB_D: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        d_ready <= 1'b1;
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_req & ~d_ready;
    assign busy      = (state != ARB_IDLE);

endmodule
